// File: rtl/seven_seg_scan_mux_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// FSM encoding, digit nibble width and the all-anodes-off pattern.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  localparam int NIBBLE_W   = 4;
  localparam int MAX_DIGITS = 32;

  // Anodes are active-low, so all ones means every digit is dark.
  localparam logic [MAX_DIGITS-1:0] AN_ALL_OFF = '1;

endpackage

// File: rtl/seven_seg_scan_mux_if.sv
// Host-side load/enable bus and display-side outputs of the scan controller.
// master drives the controls (host or bench), slave is the controller.
interface seven_seg_scan_mux_if
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) ();

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic                           enable;
  logic                           load;
  logic [NIBBLE_W*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]          dp_in;
  logic [NUM_DIGITS-1:0]          blank_mask;

  logic [NIBBLE_W-1:0]            bcd;
  logic                           dp_n;
  logic [NUM_DIGITS-1:0]          an_n;
  logic [IDX_W-1:0]               digit_idx;
  logic                           frame_done;

  modport master (
    output enable, load, digits_in, dp_in, blank_mask,
    input  bcd, dp_n, an_n, digit_idx, frame_done
  );

  modport slave (
    input  enable, load, digits_in, dp_in, blank_mask,
    output bcd, dp_n, an_n, digit_idx, frame_done
  );

endinterface

// File: rtl/seven_seg_scan_mux_slot_timer.sv
// Free-running slot counter 0..CLK_DIV-1 with decoded end-of-blank and
// end-of-slot flags; pre_slot_end flags the cycle before the slot's last cycle.
module seven_seg_slot_timer #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_blank_end,
  output logic o_slot_end,
  output logic o_pre_slot_end
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SLOT_PRE   = CNT_W'(CLK_DIV - 2);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear || (r_count == SLOT_LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_blank_end    = (r_count == BLANK_LAST);
  assign o_slot_end     = (r_count == SLOT_LAST);
  assign o_pre_slot_end = (r_count == SLOT_PRE);

endmodule

// File: rtl/seven_seg_scan_mux.sv
// N-digit common-anode scan controller: double-buffered digit store, IDLE/BLANK/SHOW
// scan FSM and registered decoder/anode outputs with an anti-ghosting blank per slot.
module seven_seg_scan_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  seven_seg_scan_mux_if.slave bus
);

  localparam int DIG_W = NIBBLE_W * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_ALL_OFF[NUM_DIGITS-1:0];

  if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_num_digits
    $fatal(1, "seven_seg_scan_mux: NUM_DIGITS must be in 2..MAX_DIGITS");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $fatal(1, "seven_seg_scan_mux: BLANK_CYCLES must be >= 1");
  end
  if (CLK_DIV <= BLANK_CYCLES) begin : g_bad_div
    $fatal(1, "seven_seg_scan_mux: CLK_DIV must exceed BLANK_CYCLES");
  end

  function automatic logic [NIBBLE_W-1:0] sel_nibble(input logic [DIG_W-1:0] d,
                                                     input logic [IDX_W-1:0] k);
    return d[int'(k)*NIBBLE_W +: NIBBLE_W];
  endfunction

  scan_state_t             r_state;
  logic [IDX_W-1:0]        r_digit_idx;
  logic [NUM_DIGITS-1:0]   r_an_n;
  logic [NIBBLE_W-1:0]     r_bcd;
  logic                    r_dp_n;
  logic                    r_frame_done;

  logic [DIG_W-1:0]        r_act_dig,  r_sh_dig;
  logic [NUM_DIGITS-1:0]   r_act_dp,   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_act_mask, r_sh_mask;
  logic                    r_pending;

  scan_state_t             w_state_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [NUM_DIGITS-1:0]   w_an_nxt;
  logic [NIBBLE_W-1:0]     w_bcd_nxt;
  logic                    w_dp_n_nxt;
  logic                    w_fd_nxt;

  logic [DIG_W-1:0]        w_act_dig,  w_sh_dig;
  logic [NUM_DIGITS-1:0]   w_act_dp,   w_sh_dp;
  logic [NUM_DIGITS-1:0]   w_act_mask, w_sh_mask;
  logic                    w_pending;

  logic                    w_clear;
  logic                    w_blank_end;
  logic                    w_slot_end;
  logic                    w_pre_slot_end;

  assign w_clear = (r_state == ST_IDLE) || !bus.enable;

  seven_seg_slot_timer #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clear        (w_clear),
    .o_blank_end    (w_blank_end),
    .o_slot_end     (w_slot_end),
    .o_pre_slot_end (w_pre_slot_end)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_digit_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_digit_idx <= w_idx_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_digit_idx;
    if (!bus.enable) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_BLANK;
          w_idx_nxt   = '0;
        end
        ST_BLANK: begin
          if (w_blank_end) w_state_nxt = ST_SHOW;
        end
        ST_SHOW: begin
          if (w_slot_end) begin
            w_state_nxt = ST_BLANK;
            w_idx_nxt   = (r_digit_idx == LAST_IDX) ? '0 : r_digit_idx + IDX_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // Buffer update: the registered frame_done marks the frame-end edge, so a swap
  // there lands exactly when digit 0 of the next frame is being loaded into bcd.
  always_comb begin
    w_act_dig  = r_act_dig;
    w_act_dp   = r_act_dp;
    w_act_mask = r_act_mask;
    w_sh_dig   = r_sh_dig;
    w_sh_dp    = r_sh_dp;
    w_sh_mask  = r_sh_mask;
    w_pending  = r_pending;
    if (bus.load) begin
      if (r_state == ST_IDLE || r_frame_done) begin
        w_act_dig  = bus.digits_in;
        w_act_dp   = bus.dp_in;
        w_act_mask = bus.blank_mask;
        w_pending  = 1'b0;
      end else begin
        w_sh_dig   = bus.digits_in;
        w_sh_dp    = bus.dp_in;
        w_sh_mask  = bus.blank_mask;
        w_pending  = 1'b1;
      end
    end else if (r_frame_done && r_pending) begin
      w_act_dig  = r_sh_dig;
      w_act_dp   = r_sh_dp;
      w_act_mask = r_sh_mask;
      w_pending  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_dig  <= '0;
      r_act_dp   <= '0;
      r_act_mask <= '0;
      r_sh_dig   <= '0;
      r_sh_dp    <= '0;
      r_sh_mask  <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_act_dig  <= w_act_dig;
      r_act_dp   <= w_act_dp;
      r_act_mask <= w_act_mask;
      r_sh_dig   <= w_sh_dig;
      r_sh_dp    <= w_sh_dp;
      r_sh_mask  <= w_sh_mask;
      r_pending  <= w_pending;
    end
  end

  // FSM output logic, computed from the next state so the outputs can be registered
  always_comb begin
    w_an_nxt   = AN_OFF;
    w_bcd_nxt  = '0;
    w_dp_n_nxt = 1'b1;
    if (w_state_nxt != ST_IDLE) begin
      w_bcd_nxt  = sel_nibble(w_act_dig, w_idx_nxt);
      w_dp_n_nxt = ~w_act_dp[w_idx_nxt];
    end
    if (w_state_nxt == ST_SHOW && !w_act_mask[w_idx_nxt]) begin
      w_an_nxt[w_idx_nxt] = 1'b0;
    end
    w_fd_nxt = bus.enable && (r_state != ST_IDLE) &&
               (r_digit_idx == LAST_IDX) && w_pre_slot_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_n       <= AN_OFF;
      r_bcd        <= '0;
      r_dp_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_an_n       <= w_an_nxt;
      r_bcd        <= w_bcd_nxt;
      r_dp_n       <= w_dp_n_nxt;
      r_frame_done <= w_fd_nxt;
    end
  end

  assign bus.an_n       = r_an_n;
  assign bus.bcd        = r_bcd;
  assign bus.dp_n       = r_dp_n;
  assign bus.digit_idx  = r_digit_idx;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Bench for seven_seg_scan_mux (4 digits, 8-cycle slots, 2 blank cycles):
// expected frame contents are queued as loads are scheduled and checked cycle by cycle.
module tb_seven_seg_scan_mux;

  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;
  localparam int FRAME = N * DIV;

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dp;
    logic [3:0]  mask;
  } frame_t;

  typedef struct {
    int          cyc;
    logic [15:0] dig;
    logic [3:0]  dp;
    logic [3:0]  mask;
  } load_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  frame_t exp_q[$];
  load_t  ld_q[$];

  seven_seg_scan_mux_if #(.NUM_DIGITS(N)) bus ();

  seven_seg_scan_mux #(
    .NUM_DIGITS   (N),
    .CLK_DIV      (DIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic frame_t mk_frame(input logic [15:0] d, input logic [3:0] p,
                                      input logic [3:0] m);
    frame_t f;
    f.dig = d; f.dp = p; f.mask = m;
    return f;
  endfunction

  function automatic load_t mk_load(input int c, input logic [15:0] d,
                                    input logic [3:0] p, input logic [3:0] m);
    load_t l;
    l.cyc = c; l.dig = d; l.dp = p; l.mask = m;
    return l;
  endfunction

  // Walks n_cyc cycles of one frame starting at its first BLANK cycle, popping the
  // expected frame and applying any load scheduled for a given cycle index.
  task automatic scan_frame(input string name, input int n_cyc);
    frame_t      e;
    load_t       l;
    int          dig, pos;
    logic [3:0]  one_hot, exp_an, exp_bcd;
    logic        exp_dpn, exp_fd;
    logic [1:0]  exp_idx;
    if (exp_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s scoreboard: got empty expected queue, required an entry", name);
      return;
    end
    e = exp_q.pop_front();
    for (int c = 0; c < n_cyc; c++) begin
      @(negedge clk);
      dig     = c / DIV;
      pos     = c % DIV;
      one_hot = 4'b0001 << dig;
      exp_an  = (pos < BLK || e.mask[dig]) ? 4'hF : ~one_hot;
      exp_bcd = e.dig[dig*4 +: 4];
      exp_dpn = ~e.dp[dig];
      exp_idx = 2'(dig);
      exp_fd  = (c == FRAME - 1);
      n_chk++;
      if ({bus.an_n, bus.bcd, bus.dp_n, bus.digit_idx, bus.frame_done} !==
          {exp_an, exp_bcd, exp_dpn, exp_idx, exp_fd}) begin
        n_fail++;
        $display("FAIL %s c=%0d: got an_n=%b bcd=%h dp_n=%b idx=%0d fd=%b, required an_n=%b bcd=%h dp_n=%b idx=%0d fd=%b",
                 name, c, bus.an_n, bus.bcd, bus.dp_n, bus.digit_idx, bus.frame_done,
                 exp_an, exp_bcd, exp_dpn, exp_idx, exp_fd);
      end
      bus.load = 1'b0;
      if (ld_q.size() > 0 && ld_q[0].cyc == c) begin
        l              = ld_q.pop_front();
        bus.load       = 1'b1;
        bus.digits_in  = l.dig;
        bus.dp_in      = l.dp;
        bus.blank_mask = l.mask;
      end
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.enable     = 1'b0;
    bus.load       = 1'b0;
    bus.digits_in  = '0;
    bus.dp_in      = '0;
    bus.blank_mask = '0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bus.an_n, bus.bcd, bus.dp_n, bus.digit_idx, bus.frame_done} !== 12'b1111_0000_1_00_0) begin
      n_fail++;
      $display("FAIL reset_held: got an_n=%b bcd=%h dp_n=%b idx=%0d fd=%b, required 1111/0/1/0/0",
               bus.an_n, bus.bcd, bus.dp_n, bus.digit_idx, bus.frame_done);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bus.an_n, bus.bcd, bus.dp_n, bus.digit_idx, bus.frame_done} !== 12'b1111_0000_1_00_0) begin
      n_fail++;
      $display("FAIL reset_released_idle: got an_n=%b bcd=%h dp_n=%b idx=%0d fd=%b, required 1111/0/1/0/0",
               bus.an_n, bus.bcd, bus.dp_n, bus.digit_idx, bus.frame_done);
    end
  endtask

  task automatic test_basic_scan();
    bus.load       = 1'b1;
    bus.digits_in  = 16'h1234;
    bus.dp_in      = 4'b0000;
    bus.blank_mask = 4'b0000;
    @(negedge clk);
    bus.load = 1'b0;
    n_chk++;
    if ({bus.an_n, bus.bcd} !== 8'hF0) begin
      n_fail++;
      $display("FAIL idle_load_dark: got an_n=%b bcd=%h, required an_n=1111 bcd=0", bus.an_n, bus.bcd);
    end
    bus.enable = 1'b1;
    exp_q.push_back(mk_frame(16'h1234, 4'b0000, 4'b0000));
    exp_q.push_back(mk_frame(16'h1234, 4'b0000, 4'b0000));
    scan_frame("basic_f0", FRAME);
    scan_frame("basic_f1", FRAME);
  endtask

  task automatic test_no_tearing();
    ld_q.push_back(mk_load(13, 16'hABCD, 4'b0000, 4'b0000));
    exp_q.push_back(mk_frame(16'h1234, 4'b0000, 4'b0000));
    exp_q.push_back(mk_frame(16'hABCD, 4'b0000, 4'b0000));
    scan_frame("tear_old", FRAME);
    scan_frame("tear_new", FRAME);
  endtask

  task automatic test_back_to_back();
    ld_q.push_back(mk_load(FRAME - 1, 16'h5678, 4'b0000, 4'b0000));
    exp_q.push_back(mk_frame(16'hABCD, 4'b0000, 4'b0000));
    exp_q.push_back(mk_frame(16'h5678, 4'b0000, 4'b0000));
    scan_frame("coinc_old", FRAME);
    scan_frame("coinc_new", FRAME);
    ld_q.push_back(mk_load(3, 16'h9E0F, 4'b0000, 4'b0000));
    ld_q.push_back(mk_load(20, 16'h6A5C, 4'b0000, 4'b0000));
    exp_q.push_back(mk_frame(16'h5678, 4'b0000, 4'b0000));
    exp_q.push_back(mk_frame(16'h6A5C, 4'b0000, 4'b0000));
    scan_frame("lastwin_old", FRAME);
    scan_frame("lastwin_new", FRAME);
  endtask

  task automatic test_mask_dp();
    ld_q.push_back(mk_load(7, 16'h1234, 4'b0001, 4'b1000));
    exp_q.push_back(mk_frame(16'h6A5C, 4'b0000, 4'b0000));
    exp_q.push_back(mk_frame(16'h1234, 4'b0001, 4'b1000));
    scan_frame("mask_old", FRAME);
    scan_frame("mask_new", FRAME);
  endtask

  task automatic test_enable_and_async_reset();
    exp_q.push_back(mk_frame(16'h1234, 4'b0001, 4'b1000));
    scan_frame("pre_disable", 20);
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.load = 1'b0;
      n_chk++;
      if ({bus.an_n, bus.bcd, bus.dp_n, bus.digit_idx, bus.frame_done} !== 12'b1111_0000_1_00_0) begin
        n_fail++;
        $display("FAIL disable_idle cyc=%0d: got an_n=%b bcd=%h dp_n=%b idx=%0d fd=%b, required 1111/0/1/0/0",
                 i, bus.an_n, bus.bcd, bus.dp_n, bus.digit_idx, bus.frame_done);
      end
    end
    bus.enable = 1'b1;
    exp_q.push_back(mk_frame(16'h1234, 4'b0001, 4'b1000));
    scan_frame("reenable", FRAME);
    ld_q.push_back(mk_load(5, 16'hFFFF, 4'b1111, 4'b0000));
    exp_q.push_back(mk_frame(16'h1234, 4'b0001, 4'b1000));
    scan_frame("pre_reset", 12);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.an_n, bus.bcd, bus.dp_n, bus.digit_idx, bus.frame_done} !== 12'b1111_0000_1_00_0) begin
      n_fail++;
      $display("FAIL async_reset: got an_n=%b bcd=%h dp_n=%b idx=%0d fd=%b, required 1111/0/1/0/0 before any edge",
               bus.an_n, bus.bcd, bus.dp_n, bus.digit_idx, bus.frame_done);
    end
    bus.enable = 1'b0;
    bus.load   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({bus.an_n, bus.bcd, bus.dp_n, bus.digit_idx, bus.frame_done} !== 12'b1111_0000_1_00_0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got an_n=%b bcd=%h dp_n=%b idx=%0d fd=%b, required 1111/0/1/0/0",
               bus.an_n, bus.bcd, bus.dp_n, bus.digit_idx, bus.frame_done);
    end
    bus.enable = 1'b1;
    exp_q.push_back(mk_frame(16'h0000, 4'b0000, 4'b0000));
    exp_q.push_back(mk_frame(16'h0000, 4'b0000, 4'b0000));
    scan_frame("cleared_f0", FRAME);
    scan_frame("cleared_f1", FRAME);
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_no_tearing();
    test_back_to_back();
    test_mask_dp();
    test_enable_and_async_reset();
    n_chk++;
    if (exp_q.size() + ld_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d expected and %0d load entries left, required 0 and 0",
               exp_q.size(), ld_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
